// File: rtl/load_store_unit_if.sv
//==============================================================================
// Module      : load_store_unit_if
// Description : Request, response and data-memory bundle for load_store_unit.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int XLEN       = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_store;
    logic [2:0]            req_funct3;
    logic [XLEN-1:0]       req_base;
    logic [XLEN-1:0]       req_offset;
    logic [XLEN-1:0]       req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [XLEN-1:0]       resp_rdata;
    logic                  resp_fault;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [XLEN-1:0]       mem_in;
    logic                  mem_wren;
    logic [1:0]            mem_width;
    logic                  mem_sign;
    logic [XLEN-1:0]       mem_out;

    modport slave (
        input  req_valid, req_store, req_funct3, req_base, req_offset, req_wdata,
        input  resp_ready, mem_out,
        output req_ready, resp_valid, resp_rdata, resp_fault,
        output mem_address, mem_in, mem_wren, mem_width, mem_sign
    );

    modport master (
        output req_valid, req_store, req_funct3, req_base, req_offset, req_wdata,
        output resp_ready, mem_out,
        input  req_ready, resp_valid, resp_rdata, resp_fault,
        input  mem_address, mem_in, mem_wren, mem_width, mem_sign
    );
endinterface

`default_nettype wire

// File: rtl/load_store_unit.sv
//==============================================================================
// Module      : load_store_unit
// Description : Sequences RISC-V loads/stores into a byte-lane data memory,
//               range-checks each access and returns data or a fault.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module load_store_unit #(
    parameter int ADDR_WIDTH = 10,
    parameter int XLEN       = 32
) (
    input  wire logic           clk,
    input  wire logic           rst,
    load_store_unit_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] c_SIZE_1 = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0] c_SIZE_2 = (ADDR_WIDTH+1)'(2);
    localparam logic [ADDR_WIDTH:0] c_SIZE_4 = (ADDR_WIDTH+1)'(4);

    state_t                state_q,  state_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  store_q,  store_d;
    logic [XLEN-1:0]       wdata_q,  wdata_d;
    logic [XLEN-1:0]       rdata_q,  rdata_d;
    logic                  fault_q,  fault_d;

    logic [XLEN-1:0]       w_eff_addr;
    logic [ADDR_WIDTH:0]   w_size;
    logic [ADDR_WIDTH:0]   w_last_byte;
    logic                  w_fault;
    logic                  w_accept;
    logic [1:0]            w_width;

    // Request checks operate on the live request so a fault can skip ISSUE.
    always_comb begin
        w_eff_addr = bus.req_base + bus.req_offset;
        case (bus.req_funct3[1:0])
            2'b00:   w_size = c_SIZE_1;
            2'b01:   w_size = c_SIZE_2;
            default: w_size = c_SIZE_4;
        endcase
        w_last_byte = {1'b0, w_eff_addr[ADDR_WIDTH-1:0]} + w_size - c_SIZE_1;
        w_fault = (bus.req_funct3[1:0] == 2'b11)
                | (bus.req_store & bus.req_funct3[2])
                | (~bus.req_store & (bus.req_funct3 == 3'b110))
                | (|w_eff_addr[XLEN-1:ADDR_WIDTH])
                | w_last_byte[ADDR_WIDTH];
        w_accept = bus.req_valid && (state_q == S_IDLE);
        case (funct3_q[1:0])
            2'b00:   w_width = 2'b00;
            2'b01:   w_width = 2'b01;
            default: w_width = 2'b11;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        funct3_d = funct3_q;
        store_d  = store_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        fault_d  = fault_q;

        bus.req_ready   = 1'b0;
        bus.resp_valid  = 1'b0;
        bus.mem_address = '0;
        bus.mem_in      = '0;
        bus.mem_wren    = 1'b0;
        bus.mem_width   = 2'b00;
        bus.mem_sign    = 1'b0;

        case (state_q)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (w_accept) begin
                    addr_d   = w_eff_addr[ADDR_WIDTH-1:0];
                    funct3_d = bus.req_funct3;
                    store_d  = bus.req_store;
                    wdata_d  = bus.req_wdata;
                    rdata_d  = '0;
                    fault_d  = w_fault;
                    state_d  = w_fault ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus.mem_address = addr_q;
                bus.mem_in      = wdata_q;
                bus.mem_wren    = store_q;
                bus.mem_width   = w_width;
                bus.mem_sign    = ~funct3_q[2];
                state_d         = store_q ? S_DONE : S_READ;
            end
            S_READ: begin
                // Address stays up while the registered read returns.
                bus.mem_address = addr_q;
                bus.mem_width   = w_width;
                bus.mem_sign    = ~funct3_q[2];
                rdata_d         = bus.mem_out;
                state_d         = S_DONE;
            end
            default: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase

        bus.resp_rdata = rdata_q;
        bus.resp_fault = fault_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            funct3_q <= 3'b000;
            store_q  <= 1'b0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            funct3_q <= funct3_d;
            store_q  <= store_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            fault_q  <= fault_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
//==============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit with a
//               big-endian registered-read byte memory model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_load_store_unit;

    logic clk;
    logic rst;
    int   vectors    = 0;
    int   miscompares = 0;

    load_store_unit_if #(.ADDR_WIDTH(10), .XLEN(32)) bus ();

    load_store_unit #(.ADDR_WIDTH(10), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte memory: lowest address holds the most significant byte.
    logic [7:0] mem [0:1023];
    logic       pre_en;
    logic [9:0] pre_addr;
    logic [7:0] pre_data;

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else if (bus.mem_wren) begin
            case (bus.mem_width)
                2'b00: mem[bus.mem_address] <= bus.mem_in[7:0];
                2'b01: begin
                    mem[bus.mem_address]         <= bus.mem_in[15:8];
                    mem[bus.mem_address + 10'd1] <= bus.mem_in[7:0];
                end
                default: begin
                    mem[bus.mem_address]         <= bus.mem_in[31:24];
                    mem[bus.mem_address + 10'd1] <= bus.mem_in[23:16];
                    mem[bus.mem_address + 10'd2] <= bus.mem_in[15:8];
                    mem[bus.mem_address + 10'd3] <= bus.mem_in[7:0];
                end
            endcase
        end
        case (bus.mem_width)
            2'b00: bus.mem_out <= bus.mem_sign
                ? {{24{mem[bus.mem_address][7]}}, mem[bus.mem_address]}
                : {24'h0, mem[bus.mem_address]};
            2'b01: bus.mem_out <= bus.mem_sign
                ? {{16{mem[bus.mem_address][7]}}, mem[bus.mem_address], mem[bus.mem_address + 10'd1]}
                : {16'h0, mem[bus.mem_address], mem[bus.mem_address + 10'd1]};
            default: bus.mem_out <= {mem[bus.mem_address], mem[bus.mem_address + 10'd1],
                                     mem[bus.mem_address + 10'd2], mem[bus.mem_address + 10'd3]};
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [9:0] a, input logic [7:0] d);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_en   = 1'b0;
    endtask

    // Issues one request from IDLE; lat counts edges after the accepting edge.
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] base,
                          input logic [31:0] off, input logic [31:0] wd,
                          output int lat, output int wr, output logic flt, output logic [31:0] rd);
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_base   = base;
        bus.req_offset = off;
        bus.req_wdata  = wd;
        tick();
        bus.req_valid = 1'b0;
        lat = 0;
        wr  = int'(bus.mem_wren);
        while (!bus.resp_valid && lat < 8) begin
            tick();
            lat++;
            wr += int'(bus.mem_wren);
        end
        flt = bus.resp_fault;
        rd  = bus.resp_rdata;
    endtask

    task automatic run(input string tag, input logic st, input logic [2:0] f3,
                       input logic [31:0] base, input logic [31:0] off, input logic [31:0] wd,
                       input int exp_lat, input int exp_wr, input logic exp_flt,
                       input logic [31:0] exp_rd);
        int          lat;
        int          wr;
        logic        flt;
        logic [31:0] rd;
        do_req(st, f3, base, off, wd, lat, wr, flt, rd);
        chk({tag, "_lat"},   32'(lat), 32'(exp_lat));
        chk({tag, "_wren"},  32'(wr),  32'(exp_wr));
        chk({tag, "_fault"}, {31'h0, flt}, {31'h0, exp_flt});
        chk({tag, "_rdata"}, rd, exp_rd);
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        pre_en         = 1'b0;
        pre_addr       = '0;
        pre_data       = '0;
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_base   = '0;
        bus.req_offset = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;
        #1;
        chk("rst_req_ready",  {31'h0, bus.req_ready},  32'h1);
        chk("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        chk("rst_mem_wren",   {31'h0, bus.mem_wren},   32'h0);
        chk("rst_mem_addr",   {22'h0, bus.mem_address}, 32'h0);
        chk("rst_rdata",      bus.resp_rdata, 32'h0);

        poke(10'h010, 8'h11); poke(10'h011, 8'h22);
        poke(10'h012, 8'h33); poke(10'h013, 8'h44);
        poke(10'h014, 8'h00);
        poke(10'h3FC, 8'hCA); poke(10'h3FD, 8'hFE);
        poke(10'h3FE, 8'hF0); poke(10'h3FF, 8'h0D);
        rst = 1'b0;
        tick();

        // Reset lands while the store is in its write cycle.
        bus.req_valid  = 1'b1;
        bus.req_store  = 1'b1;
        bus.req_funct3 = 3'b010;
        bus.req_base   = 32'h10;
        bus.req_offset = 32'h0;
        bus.req_wdata  = 32'h0000_0010;
        tick();
        bus.req_valid = 1'b0;
        chk("t1_wren_issue", {31'h0, bus.mem_wren}, 32'h1);
        #2 rst = 1'b1;
        #1;
        chk("t1_wren_rst",   {31'h0, bus.mem_wren},   32'h0);
        chk("t1_req_ready",  {31'h0, bus.req_ready},  32'h1);
        chk("t1_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
        chk("t1_mem_addr",   {22'h0, bus.mem_address}, 32'h0);
        chk("t1_mem_in",     bus.mem_in, 32'h0);
        tick();
        rst = 1'b0;
        chk("t1_mem_word", {mem[10'h010], mem[10'h011], mem[10'h012], mem[10'h013]}, 32'h1122_3344);
        tick();

        run("t2_sw",  1'b1, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1, 1, 1'b0, 32'h0);
        run("t2_lw",  1'b0, 3'b010, 32'h10, 32'h0, 32'h0,         2, 0, 1'b0, 32'hDEAD_BEEF);
        run("t3_lb",  1'b0, 3'b000, 32'h10, 32'h0, 32'h0,         2, 0, 1'b0, 32'hFFFF_FFDE);
        run("t3_lbu", 1'b0, 3'b100, 32'h13, 32'h0, 32'h0,         2, 0, 1'b0, 32'h0000_00EF);
        run("t3_lh",  1'b0, 3'b001, 32'h12, 32'h0, 32'h0,         2, 0, 1'b0, 32'hFFFF_BEEF);
        run("t3_lhu", 1'b0, 3'b101, 32'h10, 32'h0, 32'h0,         2, 0, 1'b0, 32'h0000_DEAD);
        run("t3_lw_misal", 1'b0, 3'b010, 32'h0F, 32'h2, 32'h0,    2, 0, 1'b0, 32'hADBE_EF00);

        run("t4_lw_3fe",  1'b0, 3'b010, 32'h3F0, 32'hE,        32'h0, 0, 0, 1'b1, 32'h0);
        run("t4_sw_400",  1'b1, 3'b010, 32'h400, 32'h0,        32'h5, 0, 0, 1'b1, 32'h0);
        run("t4_sb_neg",  1'b1, 3'b000, 32'h0,   32'hFFFF_FFFF, 32'h5, 0, 0, 1'b1, 32'h0);
        run("t4_f3_011",  1'b0, 3'b011, 32'h10,  32'h0,        32'h0, 0, 0, 1'b1, 32'h0);
        run("t4_st_f3_4", 1'b1, 3'b100, 32'h10,  32'h0,        32'h5, 0, 0, 1'b1, 32'h0);
        run("t4_ld_f3_6", 1'b0, 3'b110, 32'h10,  32'h0,        32'h0, 0, 0, 1'b1, 32'h0);
        chk("t4_mem_word", {mem[10'h010], mem[10'h011], mem[10'h012], mem[10'h013]}, 32'hDEAD_BEEF);

        run("t5_lw_3fc", 1'b0, 3'b010, 32'h3FC, 32'h0, 32'h0,    2, 0, 1'b0, 32'hCAFE_F00D);
        run("t5_sh_3ff", 1'b1, 3'b001, 32'h3FF, 32'h0, 32'h1234, 0, 0, 1'b1, 32'h0);

        // Response back-pressure with a competing request held on req_valid.
        begin
            int          lat;
            int          wr;
            logic        flt;
            logic [31:0] rd;
            do_req(1'b0, 3'b010, 32'h10, 32'h0, 32'h0, lat, wr, flt, rd);
            bus.req_valid  = 1'b1;
            bus.req_store  = 1'b0;
            bus.req_funct3 = 3'b100;
            bus.req_base   = 32'h13;
            bus.req_offset = 32'h0;
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("t6_hold_valid", {31'h0, bus.resp_valid}, 32'h1);
                chk("t6_hold_rdata", bus.resp_rdata, 32'hDEAD_BEEF);
                chk("t6_hold_ready", {31'h0, bus.req_ready}, 32'h0);
            end
            bus.resp_ready = 1'b1;
            tick();
            bus.resp_ready = 1'b0;
            chk("t6_rel_ready", {31'h0, bus.req_ready},  32'h1);
            chk("t6_rel_valid", {31'h0, bus.resp_valid}, 32'h0);
            tick();
            bus.req_valid = 1'b0;
            chk("t6_accepted", {31'h0, bus.req_ready}, 32'h0);
            lat = 0;
            while (!bus.resp_valid && lat < 8) begin
                tick();
                lat++;
            end
            chk("t6_lbu_lat",   32'(lat), 32'd2);
            chk("t6_lbu_rdata", bus.resp_rdata, 32'h0000_00EF);
            bus.resp_ready = 1'b1;
            tick();
            bus.resp_ready = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
